// File: rtl/masked_share_decoder_pkg.sv
// Shared definitions for the share decoder: state encoding and counter sizing.
package masked_share_decoder_pkg;

  localparam logic ST_COLLECT = 1'b0;
  localparam logic ST_OUTPUT  = 1'b1;

  typedef enum logic {
    COLLECT = ST_COLLECT,
    OUTPUT  = ST_OUTPUT
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 32'sd1;
      end
    end
    return r;
  endfunction

  // A 2-share sharing still needs one counter bit.
  function automatic int cnt_width(input int d);
    return (clog2(d) > 32'sd1) ? clog2(d) : 32'sd1;
  endfunction

endpackage

// File: rtl/masked_share_decoder_sreg.sv
// W-wide share register gadget; kept as its own instance so the accumulator is never merged upstream.
module masked_share_decoder_sreg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Enabled register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= {W{1'b0}};
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/masked_share_decoder.sv
// Recombines D serially delivered shares by XOR and presents the unmasked word on a valid/ready port.
module masked_share_decoder
  import masked_share_decoder_pkg::*;
#(
  parameter int W = 32,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_share,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  localparam int CW = cnt_width(D);
  localparam logic [CW-1:0] CNT_LAST = CW'(D - 1);

  if (D < 2) begin : g_d_check
    $error("masked_share_decoder: D must be at least 2");
  end

  state_e        state_r;
  state_e        state_n;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_n;
  logic          acc_en_s;
  logic [W-1:0]  acc_d_s;
  logic [W-1:0]  acc_r;

  masked_share_decoder_sreg #(
    .W(W)
  ) u_acc (
    .clk(clk),
    .rst(rst),
    .en (acc_en_s),
    .d  (acc_d_s),
    .q  (acc_r)
  );

  // Next state, counter and accumulator update; in_share is only selected on an accepted share.
  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    acc_en_s = 1'b0;
    acc_d_s  = acc_r;
    case (state_r)
      COLLECT: begin
        if (in_valid) begin
          acc_en_s = 1'b1;
          acc_d_s  = (cnt_r == {CW{1'b0}}) ? in_share : (acc_r ^ in_share);
          if (cnt_r == CNT_LAST) begin
            cnt_n   = {CW{1'b0}};
            state_n = OUTPUT;
          end else begin
            cnt_n = cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end else begin
          state_n = COLLECT;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          acc_en_s = 1'b1;
          acc_d_s  = {W{1'b0}};
          state_n  = COLLECT;
        end else begin
          state_n = OUTPUT;
        end
      end
      default: begin
        state_n  = COLLECT;
        cnt_n    = {CW{1'b0}};
        acc_en_s = 1'b1;
        acc_d_s  = {W{1'b0}};
      end
    endcase
  end

  // FSM state and share counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= COLLECT;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  assign in_ready  = (state_r == COLLECT);
  assign out_valid = (state_r == OUTPUT);
  assign out_data  = acc_r & {W{out_valid}};
  assign busy      = (state_r == OUTPUT) | (cnt_r != {CW{1'b0}});

endmodule
